dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters: one clock; reset is asynchronous and active-low.
REQ-002 PRIO, default 0, tie-break mode: 0 = round-robin, 1 = fixed core priority.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 c_req  in  1  core load/store request; held stable until c_done.
REQ-006 c_we  in  1  core write enable.
REQ-007 c_addr  in  32  core byte address.
REQ-008 c_wdata  in  32  core store data.
REQ-009 c_func3  in  3  core load/store width code, passed to memory.
REQ-010 c_stall  out  1  core must hold its PC and registers.
REQ-011 c_done  out  1  one-cycle completion pulse for the core.
REQ-012 c_rdata  out  32  core load data, held until the next core read completes.
REQ-013 d_req, d_we  in  1 each  debug/loader request and write enable, word access only.
REQ-014 d_addr, d_wdata  in  32 each  debug address and write data.
REQ-015 d_gnt  out  1  one-cycle pulse: debug request accepted; inputs may then change.
REQ-016 d_rvalid  out  1  one-cycle pulse: d_rdata valid, debug reads only.
REQ-017 d_rdata  out  32  debug read data, held until the next debug read.
REQ-018 m_en, m_we  out  1 each  memory port enable and write.
REQ-019 m_addr, m_wdata  out  32 each  memory address and write data; m_func3  out  3.
REQ-020 m_rdata  in  32  memory read data, valid the cycle after m_en with m_we=0.

Function
REQ-021 States: IDLE, ACC, WAIT, DONE; an owner flag (CORE/DBG) is latched at grant.
REQ-022 IDLE transitions: no request -> IDLE; exactly one request -> grant it, go to ACC.
REQ-023 IDLE with both requests: PRIO=0 grants the requester not granted last; PRIO=1 grants the core.
REQ-024 On grant, latch the address, write data, write enable and func3; debug func3 is forced to 3'b010; d_gnt pulses in the grant cycle when debug is the owner.
REQ-025 ACC: m_en=1 and m_we/m_addr/m_wdata/m_func3 are driven from the latch; next state is WAIT.
REQ-026 WAIT: m_en=0; if the access is a read, capture m_rdata into the owner's rdata register at the clock edge; next state is DONE.
REQ-027 DONE: core owner gives c_done=1, debug read gives d_rvalid=1; no grant is issued; next state is IDLE.
REQ-028 Timing: a request granted in cycle T gets m_en in T+1, data capture at the end of T+2, and done/rvalid in T+3; minimum spacing between grants is 4 cycles.
REQ-029 c_stall = c_req AND NOT c_done, combinational; this includes the cycles while debug owns the port.
REQ-030 m_en, m_we and the handshake pulses are 0 in every state not listed above; m_addr, m_wdata and m_func3 hold their last value.
REQ-031 c_rdata is not modified by core writes or by debug accesses; d_rdata is not modified by core accesses.
REQ-032 A change on c_req during ACC, WAIT or DONE does not abort the in-flight access.

Reset
REQ-033 reset low forces IDLE immediately (asynchronously) and clears m_en, m_we, c_done, d_gnt, d_rvalid, c_rdata, d_rdata, m_addr, m_wdata and m_func3 to 0.
REQ-034 A reset during ACC, WAIT or DONE aborts the access with no done or rvalid pulse.
REQ-035 The last-grant register resets to DBG, so the core wins the first tie.
REQ-036 After reset deasserts, the first grant can occur on the first rising edge.

Verification
REQ-037 Core read: c_req=1, c_we=0, c_addr=0x10, with the memory returning 0xDEADBEEF -> m_en in T+1 with m_addr=0x10, c_done in T+3, c_rdata=0xDEADBEEF, and c_stall high for T..T+2.
REQ-038 Core write: c_we=1, c_wdata=0x55, c_func3=3'b000 -> a single m_en/m_we cycle carrying m_func3=000, c_done in T+3, c_rdata unchanged.
REQ-039 Both requests held continuously with PRIO=0 -> grant order CORE, DBG, CORE, DBG, with grants 4 cycles apart; with PRIO=1 -> the core is always granted.
REQ-040 Debug read at 0x20 while the core is idle -> d_gnt in T, m_func3=3'b010 in T+1, d_rvalid in T+3 with d_rdata equal to the memory data, no c_done.
REQ-041 Core request issued while debug owns the port -> c_stall stays high until the core's own c_done, and the core grant occurs in the IDLE cycle after debug's DONE.
REQ-042 reset pulsed low during WAIT -> m_en=0 at once, no c_done, state IDLE, and a pending c_req is granted on the first edge after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master (core/debug) arbiter for a single data-memory port
module dmem_arbiter #(
  parameter bit PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_func3,
  output logic        c_stall,
  output logic        c_done,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_func3,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Debug accesses are always full words.
  localparam logic [2:0] FUNC3_WORD = 3'b010;

  state_t      r_state;
  state_t      w_next_state;

  // Owner of the in-flight access: 1 = debug, 0 = core.
  logic        r_owner_dbg;
  // Requester granted most recently: 1 = debug, 0 = core.
  logic        r_last_dbg;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_func3;
  logic [31:0] r_c_rdata;
  logic [31:0] r_d_rdata;

  logic        w_grant_core;
  logic        w_grant_dbg;
  logic        w_m_en;
  logic        w_m_we;
  logic        w_c_done;
  logic        w_d_gnt;
  logic        w_d_rvalid;

  // Next-state, grant decision and per-state port/handshake outputs.
  always_comb begin
    w_next_state = r_state;
    w_grant_core = 1'b0;
    w_grant_dbg  = 1'b0;
    w_m_en       = 1'b0;
    w_m_we       = 1'b0;
    w_c_done     = 1'b0;
    w_d_gnt      = 1'b0;
    w_d_rvalid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (c_req && d_req) begin
          // Tie: fixed mode favours the core, round-robin favours whoever lost last time.
          if (PRIO || r_last_dbg) begin
            w_grant_core = 1'b1;
          end else begin
            w_grant_dbg  = 1'b1;
          end
        end else if (c_req) begin
          w_grant_core = 1'b1;
        end else if (d_req) begin
          w_grant_dbg  = 1'b1;
        end
        if (w_grant_core || w_grant_dbg) begin
          w_next_state = S_ACC;
        end
        w_d_gnt = w_grant_dbg;
      end
      S_ACC: begin
        w_m_en       = 1'b1;
        w_m_we       = r_we;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        w_c_done     = ~r_owner_dbg;
        w_d_rvalid   = r_owner_dbg & ~r_we;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the winning request and remember who won for round-robin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner_dbg <= 1'b0;
      r_last_dbg  <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_func3     <= 3'b000;
    end else if (w_grant_core) begin
      r_owner_dbg <= 1'b0;
      r_last_dbg  <= 1'b0;
      r_we        <= c_we;
      r_addr      <= c_addr;
      r_wdata     <= c_wdata;
      r_func3     <= c_func3;
    end else if (w_grant_dbg) begin
      r_owner_dbg <= 1'b1;
      r_last_dbg  <= 1'b1;
      r_we        <= d_we;
      r_addr      <= d_addr;
      r_wdata     <= d_wdata;
      r_func3     <= FUNC3_WORD;
    end
  end

  // Route read data into the owner's register at the end of WAIT; writes leave both untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_rdata <= 32'h0;
      r_d_rdata <= 32'h0;
    end else if (r_state == S_WAIT && !r_we) begin
      if (r_owner_dbg) begin
        r_d_rdata <= m_rdata;
      end else begin
        r_c_rdata <= m_rdata;
      end
    end
  end

  assign m_en     = w_m_en;
  assign m_we     = w_m_we;
  assign m_addr   = r_addr;
  assign m_wdata  = r_wdata;
  assign m_func3  = r_func3;
  assign c_done   = w_c_done;
  assign c_stall  = c_req & ~w_c_done;
  assign c_rdata  = r_c_rdata;
  assign d_gnt    = w_d_gnt;
  assign d_rvalid = w_d_rvalid;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata;
  logic [2:0]  c_func3;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;

  logic        c_stall, c_done, d_gnt, d_rvalid, m_en, m_we;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [2:0]  m_func3;

  logic        p1_c_stall, p1_c_done, p1_d_gnt, p1_d_rvalid, p1_m_en, p1_m_we;
  logic [31:0] p1_c_rdata, p1_d_rdata, p1_m_addr, p1_m_wdata, p1_m_rdata;
  logic [2:0]  p1_m_func3;
  assign p1_m_rdata = 32'h0;

  dmem_arbiter #(.PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_func3(c_func3),
    .c_stall(c_stall), .c_done(c_done), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_func3(m_func3),
    .m_rdata(m_rdata)
  );

  dmem_arbiter #(.PRIO(1'b1)) dut_p1 (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_func3(c_func3),
    .c_stall(p1_c_stall), .c_done(p1_c_done), .c_rdata(p1_c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(p1_d_gnt), .d_rvalid(p1_d_rvalid), .d_rdata(p1_d_rdata),
    .m_en(p1_m_en), .m_we(p1_m_we), .m_addr(p1_m_addr), .m_wdata(p1_m_wdata), .m_func3(p1_m_func3),
    .m_rdata(p1_m_rdata)
  );

  // Memory environment: one-cycle read latency, preload port for the bench.
  logic [31:0] mem [64];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (m_en) begin
      if (m_we) mem[m_addr[7:2]] <= m_wdata;
      else m_rdata <= mem[m_addr[7:2]];
    end
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] exp_c_rdata, exp_d_rdata;

  task test_reset();
    reset = 1'b0; pre_we = 1'b0; pre_idx = 6'd0; pre_data = 32'h0;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_func3 = 3'b000;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = (i == 4) ? 32'hDEADBEEF : $urandom;
      @(negedge clk); pre_we = 1'b1; pre_idx = i[5:0]; pre_data = ref_mem[i];
    end
    @(negedge clk); pre_we = 1'b0;
    c_req = 1'b1;
    @(negedge clk); #1;
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL reset_m_en: got %b exp 0", m_en); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL reset_m_we: got %b exp 0", m_we); end
    checks++; if ({c_done, d_gnt, d_rvalid} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b exp 000", {c_done, d_gnt, d_rvalid}); end
    checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL reset_c_rdata: got %h exp 0", c_rdata); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h exp 0", d_rdata); end
    checks++; if ({m_addr, m_wdata, m_func3} !== 67'h0) begin errors++; $display("FAIL reset_m_bus: got %h/%h/%b exp 0", m_addr, m_wdata, m_func3); end
    checks++; if (c_stall !== 1'b1) begin errors++; $display("FAIL reset_c_stall: got %b exp 1", c_stall); end
    c_req = 1'b0;
    exp_c_rdata = 32'h0; exp_d_rdata = 32'h0;
    @(negedge clk); reset = 1'b1;
  endtask

  task test_core_read();
    @(negedge clk); c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_func3 = 3'b010; #1;
    checks++; if ({c_stall, m_en} !== 2'b10) begin errors++; $display("FAIL cr_T: got stall/en %b exp 10", {c_stall, m_en}); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        checks++; if ({m_en, m_we, m_addr, c_stall} !== {1'b1, 1'b0, 32'h10, 1'b1}) begin errors++; $display("FAIL cr_T1: got en=%b we=%b addr=%h stall=%b exp 1 0 10 1", m_en, m_we, m_addr, c_stall); end
      end else if (k == 2) begin
        checks++; if ({m_en, c_stall, c_done} !== 3'b010) begin errors++; $display("FAIL cr_T2: got en/stall/done %b exp 010", {m_en, c_stall, c_done}); end
      end else begin
        checks++; if ({c_done, c_stall} !== 2'b10) begin errors++; $display("FAIL cr_T3: got done/stall %b exp 10", {c_done, c_stall}); end
        checks++; if (c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cr_rdata: got %h exp deadbeef", c_rdata); end
      end
    end
    exp_c_rdata = 32'hDEADBEEF;
    @(negedge clk); c_req = 1'b0; #1;
    checks++; if (c_done !== 1'b0) begin errors++; $display("FAIL cr_done_once: got %b exp 0", c_done); end
  endtask

  task test_core_write();
    int en_cnt;
    en_cnt = 0;
    @(negedge clk); c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'h55; c_func3 = 3'b000; #1;
    en_cnt += m_en;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      en_cnt += m_en;
      if (k == 1) begin
        checks++; if ({m_we, m_func3, m_wdata} !== {1'b1, 3'b000, 32'h55}) begin errors++; $display("FAIL cw_T1: got we=%b f3=%b wd=%h exp 1 000 55", m_we, m_func3, m_wdata); end
      end
      if (k == 3) begin
        checks++; if (c_done !== 1'b1) begin errors++; $display("FAIL cw_done: got %b exp 1", c_done); end
        checks++; if (c_rdata !== exp_c_rdata) begin errors++; $display("FAIL cw_rdata: got %h exp %h", c_rdata, exp_c_rdata); end
      end
    end
    checks++; if (en_cnt != 1) begin errors++; $display("FAIL cw_en_count: got %0d exp 1", en_cnt); end
    ref_mem[16] = 32'h55;
    @(negedge clk); c_req = 1'b0; c_we = 1'b0;
  endtask

  task test_debug_read();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL dr_gnt: got %b exp 1", d_gnt); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); if (k == 1) d_req = 1'b0; #1;
      done_cnt += c_done;
      if (k == 1) begin
        checks++; if ({m_en, m_func3, m_addr, d_gnt} !== {1'b1, 3'b010, 32'h20, 1'b0}) begin errors++; $display("FAIL dr_T1: got en=%b f3=%b addr=%h gnt=%b exp 1 010 20 0", m_en, m_func3, m_addr, d_gnt); end
      end
      if (k == 3) begin
        checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL dr_rvalid: got %b exp 1", d_rvalid); end
        checks++; if (d_rdata !== ref_mem[8]) begin errors++; $display("FAIL dr_rdata: got %h exp %h", d_rdata, ref_mem[8]); end
        checks++; if (c_rdata !== exp_c_rdata) begin errors++; $display("FAIL dr_c_rdata_kept: got %h exp %h", c_rdata, exp_c_rdata); end
      end
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL dr_no_c_done: got %0d exp 0", done_cnt); end
    exp_d_rdata = ref_mem[8];
    @(negedge clk);
  endtask

  task test_core_during_debug();
    int first_done, stall_low;
    logic [31:0] wd;
    first_done = -1; stall_low = 0;
    wd = $urandom;
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = wd; #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL cdd_gnt: got %b exp 1", d_gnt); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin d_req = 1'b0; d_we = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h24; c_func3 = 3'b010; end
      #1;
      if (c_done === 1'b1 && first_done < 0) first_done = k;
      if (k < 7 && c_stall !== 1'b1) stall_low++;
      if (k == 4) begin
        checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL cdd_idle_en: got %b exp 0", m_en); end
      end
      if (k == 5) begin
        checks++; if ({m_en, m_addr} !== {1'b1, 32'h24}) begin errors++; $display("FAIL cdd_core_acc: got en=%b addr=%h exp 1 24", m_en, m_addr); end
      end
    end
    ref_mem[9] = wd;
    exp_c_rdata = wd;
    checks++; if (first_done != 7) begin errors++; $display("FAIL cdd_done_cycle: got %0d exp 7", first_done); end
    checks++; if (stall_low != 0) begin errors++; $display("FAIL cdd_stall: got %0d low cycles exp 0", stall_low); end
    checks++; if (c_rdata !== wd) begin errors++; $display("FAIL cdd_rdata: got %h exp %h", c_rdata, wd); end
    @(negedge clk); c_req = 1'b0;
  endtask

  task test_arbitration();
    byte obs_who[$], p1_who[$];
    int  obs_t[$], p1_t[$];
    byte exp_who[4];
    int  exp_t[4];
    byte last;
    @(negedge clk); reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h30; c_func3 = 3'b010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h34;
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (c_done === 1'b1) begin obs_who.push_back("C"); obs_t.push_back(k - 3); end
      if (d_gnt === 1'b1) begin obs_who.push_back("D"); obs_t.push_back(k); end
      if (p1_c_done === 1'b1) begin p1_who.push_back("C"); p1_t.push_back(k - 3); end
      if (p1_d_gnt === 1'b1) begin p1_who.push_back("D"); p1_t.push_back(k); end
    end
    last = "D";
    for (int g = 0; g < 4; g++) begin
      exp_who[g] = (last == "D") ? "C" : "D";
      exp_t[g] = 4 * g;
      last = exp_who[g];
    end
    checks++; if (obs_who.size() != 4) begin errors++; $display("FAIL rr_count: got %0d grants exp 4", obs_who.size()); end
    for (int g = 0; g < 4; g++) begin
      if (g < obs_who.size()) begin
        checks++; if (obs_who[g] != exp_who[g] || obs_t[g] != exp_t[g]) begin errors++; $display("FAIL rr_grant%0d: got %s@%0d exp %s@%0d", g, obs_who[g], obs_t[g], exp_who[g], exp_t[g]); end
      end
    end
    checks++; if (p1_who.size() != 4) begin errors++; $display("FAIL fixed_count: got %0d grants exp 4", p1_who.size()); end
    for (int g = 0; g < 4; g++) begin
      if (g < p1_who.size()) begin
        checks++; if (p1_who[g] != "C" || p1_t[g] != 4 * g) begin errors++; $display("FAIL fixed_grant%0d: got %s@%0d exp C@%0d", g, p1_who[g], p1_t[g], 4 * g); end
      end
    end
    checks++; if ({c_rdata, d_rdata} !== {ref_mem[12], ref_mem[13]}) begin errors++; $display("FAIL rr_rdata: got %h/%h exp %h/%h", c_rdata, d_rdata, ref_mem[12], ref_mem[13]); end
    exp_c_rdata = ref_mem[12]; exp_d_rdata = ref_mem[13];
    @(negedge clk); c_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  task test_reset_in_wait();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk); c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_func3 = 3'b010;
    @(negedge clk);
    @(negedge clk); reset = 1'b0; #1;
    checks++; if ({m_en, c_done, c_stall} !== 3'b001) begin errors++; $display("FAIL rw_abort: got en/done/stall %b exp 001", {m_en, c_done, c_stall}); end
    checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL rw_c_rdata_clr: got %h exp 0", c_rdata); end
    exp_c_rdata = 32'h0; exp_d_rdata = 32'h0;
    @(negedge clk); reset = 1'b1; #1;
    done_cnt += c_done;
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL rw_R0_en: got %b exp 0", m_en); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        checks++; if ({m_en, m_addr} !== {1'b1, 32'h10}) begin errors++; $display("FAIL rw_R1: got en=%b addr=%h exp 1 10", m_en, m_addr); end
      end
      if (k < 3) done_cnt += c_done;
      if (k == 3) begin
        checks++; if (done_cnt != 0 || c_done !== 1'b1) begin errors++; $display("FAIL rw_done: got early=%0d done=%b exp 0 1", done_cnt, c_done); end
        checks++; if (c_rdata !== ref_mem[4]) begin errors++; $display("FAIL rw_rdata: got %h exp %h", c_rdata, ref_mem[4]); end
      end
    end
    exp_c_rdata = ref_mem[4];
    @(negedge clk); c_req = 1'b0;
  endtask

  task test_random();
    bit          is_dbg, we;
    int          idx, gap;
    logic [31:0] data, addr;
    logic        done_sig, exp_done;
    for (int n = 0; n < 40; n++) begin
      is_dbg = $urandom_range(0, 1); we = $urandom_range(0, 1);
      idx = $urandom_range(0, 63); data = $urandom; gap = $urandom_range(0, 2);
      addr = idx << 2;
      for (int g = 0; g < gap; g++) @(negedge clk);
      @(negedge clk);
      if (is_dbg) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = data; end
      else begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = data; c_func3 = 3'b010; end
      #1;
      checks++; if ({d_gnt, c_stall} !== {is_dbg, ~is_dbg}) begin errors++; $display("FAIL rnd%0d_grant: got gnt/stall %b%b exp %b%b", n, d_gnt, c_stall, is_dbg, ~is_dbg); end
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk); if (k == 1) d_req = 1'b0; #1;
        if (k == 1) begin
          checks++; if ({m_en, m_we, m_addr, m_func3} !== {1'b1, we, addr, 3'b010}) begin errors++; $display("FAIL rnd%0d_acc: got en=%b we=%b addr=%h f3=%b exp 1 %b %h 010", n, m_en, m_we, m_addr, m_func3, we, addr); end
          if (we) begin
            checks++; if (m_wdata !== data) begin errors++; $display("FAIL rnd%0d_wdata: got %h exp %h", n, m_wdata, data); end
          end
        end
        done_sig = is_dbg ? d_rvalid : c_done;
        exp_done = (k == 3) && (!is_dbg || !we);
        checks++; if (done_sig !== exp_done) begin errors++; $display("FAIL rnd%0d_done_k%0d: got %b exp %b", n, k, done_sig, exp_done); end
      end
      if (we) ref_mem[idx] = data;
      else if (is_dbg) exp_d_rdata = ref_mem[idx];
      else exp_c_rdata = ref_mem[idx];
      checks++; if ({c_rdata, d_rdata} !== {exp_c_rdata, exp_d_rdata}) begin errors++; $display("FAIL rnd%0d_rdata: got %h/%h exp %h/%h", n, c_rdata, d_rdata, exp_c_rdata, exp_d_rdata); end
      @(negedge clk); c_req = 1'b0; c_we = 1'b0; d_we = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_core_read();
    test_core_write();
    test_debug_read();
    test_core_during_debug();
    test_arbitration();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
